btn_capture_display: RTL
========================

BTN_CAPTURE_DISPLAY -- requirements
Module: btn_capture_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of hex digits displayed (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles required to accept a button level change (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles each digit stays selected (>=1).
REQ-004 SHALL have parameter BLANK_LZ, default 1, meaning leading-zero digits are blanked when 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all flops are on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port button, input, 1, raw asynchronous capture button, active-low (0 = pressed).
REQ-008 SHALL have port button_clr, input, 1, raw asynchronous clear button, active-low.
REQ-009 SHALL have port value, output, 4*DIGITS, the last captured counter value.
REQ-010 SHALL have port capture, output, 1, a one-cycle pulse in the cycle after value updates.
REQ-011 SHALL have port segm, output, 7, segment drive for the selected digit, active-low, bit 0 = segment a.
REQ-012 SHALL have port dig_sel, output, DIGITS, digit enables, one-hot active-low.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, followed by a debouncer whose stable level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL restart the count.
REQ-014 SHALL generate a press pulse for one cycle when a debounced level goes 1->0; a release (0->1) SHALL generate no pulse.
REQ-015 SHALL run a 4*DIGITS-bit free counter that increments every cycle and wraps from all-ones to 0.
REQ-016 On a capture press pulse, value SHALL load the counter's current (pre-increment) value on the next edge, and capture SHALL be high in the cycle after that edge.
REQ-017 On a clear press pulse, value SHALL become 0 on the next edge with no capture pulse; on a simultaneous capture and clear pulse, clear SHALL win.
REQ-018 A held button SHALL produce exactly one capture, regardless of hold length.
REQ-019 SHALL run a prescaler counting 0..SCAN_DIV-1; at terminal count the digit index SHALL advance and wrap from DIGITS-1 to 0.
REQ-020 segm and dig_sel SHALL be registered together, with one cycle of latency from the index/value used, so that they never disagree.
REQ-021 segm SHALL encode nibble[index] of value using hex glyphs 0-F (for example 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110).
REQ-022 With BLANK_LZ=1, any digit above the most significant nonzero nibble SHALL show 7'b1111111; digit 0 SHALL always be shown, so value 0 displays "0".
REQ-023 With DIGITS=1, the scan index SHALL stay 0 and dig_sel SHALL stay at 0 after reset.

Reset
REQ-024 While rst_n=0, the block SHALL hold: counter 0, value 0, capture 0, prescaler 0, index 0, synchronizers and debounced levels 1 (released), debounce counters 0, segm 7'b1111111, dig_sel all ones.
REQ-025 Reset asserted mid-debounce or mid-scan SHALL abort it immediately; a button held low through reset release SHALL produce no press until it has been released and pressed again.
REQ-026 The first scan output SHALL appear on the first edge after reset release.

Structure
REQ-027 The 16-entry glyph table, blank pattern 7'b1111111 and segment bit ordering SHALL live in a shared package, seg7_pkg.
REQ-028 Synchronizer, debouncer and edge detect SHALL form one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES, ports clk, rst_n, btn_in, level, press), instantiated twice.

Verification
REQ-029 DIGITS=2, DEBOUNCE_CYCLES=4: button low for 3 cycles then high -> no capture pulse and value unchanged.
REQ-030 DIGITS=2, DEBOUNCE_CYCLES=4: button held low for 20 cycles while the counter reads 0x3C in the press cycle -> one capture pulse and value=0x3C.
REQ-031 DIGITS=2: counter wraps 0xFF->0x00; a capture on the wrap cycle -> value=0xFF.
REQ-032 Capture and clear presses debounced into the same cycle -> value=0x00 and no capture pulse.
REQ-033 DIGITS=4, SCAN_DIV=3, value=0x00A5 -> dig_sel cycles 1110,1101,1011,0111 every 3 cycles, with segm = "5", "A", blank, blank.
REQ-034 rst_n pulsed low mid-scan with button held low -> outputs at reset values, and no capture after release until the button is re-pressed.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment glyphs, blank pattern and segment bit order
package seg7_pkg;

    // Segment bit positions; drive is active-low.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and press edge detector
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          prev;
    logic          armed;
    logic [1:0]    primed;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            level  <= 1'b1;
            prev   <= 1'b1;
            armed  <= 1'b0;
            primed <= 2'd0;
            cnt    <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            prev  <= level;
            // Arm only once a real released sample has crossed the synchronizer,
            // so a button held through reset cannot fire.
            if (primed != 2'd2)
                primed <= primed + 2'd1;
            else if (sync2)
                armed <= 1'b1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = prev & ~level & armed;

endmodule

// File: rtl/btn_capture_display.sv
// rtl/btn_capture_display.sv - captures a free-running counter on a button press and scans it to a hex display
module btn_capture_display
    import seg7_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_DIV        = 1000,
    parameter int BLANK_LZ        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  button,
    input  logic                  button_clr,
    output logic [4*DIGITS-1:0]   value,
    output logic                  capture,
    output logic [6:0]            segm,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [1:0]        unused_levels;
    logic              cap_press;
    logic              clr_press;
    logic [W-1:0]      cnt;
    logic [PW-1:0]     pre;
    logic [IW-1:0]     idx;
    logic [3:0]        nib;
    logic              upper_zero;
    logic              blank;
    logic [DIGITS-1:0] sel_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cap (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (button),
        .level  (unused_levels[0]),
        .press  (cap_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (button_clr),
        .level  (unused_levels[1]),
        .press  (clr_press)
    );

    // A digit is blank when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        nib        = 4'h0;
        upper_zero = 1'b1;
        sel_n      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == int'(idx)) begin
                nib      = value[4*i +: 4];
                sel_n[i] = 1'b0;
            end
            if (i >= int'(idx) && value[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        blank = (BLANK_LZ != 0) && (idx != '0) && upper_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            value   <= '0;
            capture <= 1'b0;
            pre     <= '0;
            idx     <= '0;
            segm    <= SEG_BLANK;
            dig_sel <= '1;
        end else begin
            cnt     <= cnt + 1'b1;
            capture <= cap_press & ~clr_press;
            if (clr_press)
                value <= '0;
            else if (cap_press)
                value <= cnt;
            if (pre == PW'(SCAN_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            segm    <= blank ? SEG_BLANK : glyph(nib);
            dig_sel <= sel_n;
        end
    end

endmodule
